// File: rtl/bf_loop_scanner_if.sv
// Request/response and program-ROM signals between the bf core and its bracket scanner.
// The slave modport is the scanner's view; the master modport belongs to the core and ROM.
interface bf_loop_scanner_if #(
    parameter int ADDR_W = 9
);
    logic              start;
    logic              dir;
    logic [ADDR_W-1:0] start_pc;
    logic [ADDR_W-1:0] rom_addr;
    logic [7:0]        rom_data;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] match_pc;
    logic              error;

    modport slave (
        input  start, dir, start_pc, rom_data,
        output rom_addr, busy, done, match_pc, error
    );

    modport master (
        output start, dir, start_pc, rom_data,
        input  rom_addr, busy, done, match_pc, error
    );
endinterface

// File: rtl/bf_loop_scanner.sv
// Finds the bracket matching the one at start_pc by walking program memory one byte per cycle.
// A depth counter tracks nesting; running off either end of the program, or overflowing the counter, is an error.
module bf_loop_scanner #(
    parameter int ADDR_W   = 9,
    parameter int DEPTH_W  = 9,
    parameter int PROG_LEN = 512
) (
    input logic              sys_clk,
    input logic              rst,
    bf_loop_scanner_if.slave bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [1:0] S_ERR  = 2'd3;

    localparam logic [ADDR_W-1:0]  LAST_PC   = ADDR_W'(PROG_LEN - 1);
    localparam logic [DEPTH_W-1:0] DEPTH_MAX = '1;
    localparam logic [7:0]         CH_LBRK   = 8'h5B;
    localparam logic [7:0]         CH_RBRK   = 8'h5D;

    logic [1:0]         r_state;
    logic               r_dir;
    logic [DEPTH_W-1:0] r_depth;
    logic [ADDR_W-1:0]  r_rom_addr;
    logic [ADDR_W-1:0]  r_match_pc;

    logic              w_open;
    logic              w_close;
    logic              w_at_end;
    logic [ADDR_W-1:0] w_next_addr;

    // Scanning backward swaps the roles of '[' and ']'.
    always_comb begin
        w_open      = r_dir ? (bus.rom_data == CH_RBRK) : (bus.rom_data == CH_LBRK);
        w_close     = r_dir ? (bus.rom_data == CH_LBRK) : (bus.rom_data == CH_RBRK);
        w_at_end    = r_dir ? (r_rom_addr == '0) : (r_rom_addr == LAST_PC);
        w_next_addr = r_dir ? (r_rom_addr - 1'b1) : (r_rom_addr + 1'b1);
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_dir      <= 1'b0;
            r_depth    <= '0;
            r_rom_addr <= '0;
            r_match_pc <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_dir   <= bus.dir;
                        r_depth <= '0;
                        if (!bus.dir) begin
                            if (bus.start_pc >= LAST_PC) begin
                                r_state <= S_ERR;
                            end else begin
                                r_rom_addr <= bus.start_pc + 1'b1;
                                r_state    <= S_SCAN;
                            end
                        end else begin
                            if (bus.start_pc == '0) begin
                                r_state <= S_ERR;
                            end else begin
                                r_rom_addr <= bus.start_pc - 1'b1;
                                r_state    <= S_SCAN;
                            end
                        end
                    end
                end
                S_SCAN: begin
                    if (w_close && r_depth == '0) begin
                        r_match_pc <= r_rom_addr;
                        r_state    <= S_DONE;
                    end else if (w_open && r_depth == DEPTH_MAX) begin
                        r_state <= S_ERR;
                    end else begin
                        if (w_close)
                            r_depth <= r_depth - 1'b1;
                        else if (w_open)
                            r_depth <= r_depth + 1'b1;
                        // Unmatched byte at the program edge: stop rather than wrap.
                        if (w_at_end)
                            r_state <= S_ERR;
                        else
                            r_rom_addr <= w_next_addr;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.rom_addr = r_rom_addr;
    assign bus.match_pc = r_match_pc;
    assign bus.busy     = (r_state == S_SCAN);
    assign bus.done     = (r_state == S_DONE);
    assign bus.error    = (r_state == S_ERR);
endmodule

// File: tb/tb_bf_loop_scanner.sv
// Scoreboard bench: three scanner instances with different program lengths and depth widths.
module tb_bf_loop_scanner;
    logic sys_clk = 1'b0;
    logic rst     = 1'b1;
    int   cyc     = 0;
    int   n_cmp   = 0;
    int   n_bad   = 0;

    typedef struct {
        bit err;
        int pc;
        int cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    logic [7:0] rom0 [512];
    logic [7:0] rom1 [512];
    logic [7:0] rom2 [512];

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    bf_loop_scanner_if #(.ADDR_W(9)) ifa ();
    bf_loop_scanner_if #(.ADDR_W(9)) ifb ();
    bf_loop_scanner_if #(.ADDR_W(9)) ifc ();

    assign ifa.rom_data = rom0[ifa.rom_addr];
    assign ifb.rom_data = rom1[ifb.rom_addr];
    assign ifc.rom_data = rom2[ifc.rom_addr];

    bf_loop_scanner #(.ADDR_W(9), .DEPTH_W(9), .PROG_LEN(9)) dut_a (
        .sys_clk(sys_clk), .rst(rst), .bus(ifa));
    bf_loop_scanner #(.ADDR_W(9), .DEPTH_W(9), .PROG_LEN(3)) dut_b (
        .sys_clk(sys_clk), .rst(rst), .bus(ifb));
    bf_loop_scanner #(.ADDR_W(9), .DEPTH_W(2), .PROG_LEN(10)) dut_c (
        .sys_clk(sys_clk), .rst(rst), .bus(ifc));

    task automatic cmp(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int qsize(input int id);
        case (id)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic push(input int id, input bit err, input int pc, input int c);
        exp_t x;
        x.err = err; x.pc = pc; x.cyc = c;
        case (id)
            0:       q0.push_back(x);
            1:       q1.push_back(x);
            default: q2.push_back(x);
        endcase
    endtask

    task automatic check(input int id, input logic d, input logic e, input int pc);
        exp_t x;
        n_cmp++;
        if (qsize(id) == 0) begin
            n_bad++;
            $display("FAIL unexpected_out inst%0d: got done=%0d error=%0d at cyc %0d expected none",
                     id, d, e, cyc);
            return;
        end
        case (id)
            0:       x = q0.pop_front();
            1:       x = q1.pop_front();
            default: x = q2.pop_front();
        endcase
        if (d == e || e != x.err || pc != x.pc || cyc != x.cyc) begin
            n_bad++;
            $display("FAIL result inst%0d: got done=%0d error=%0d pc=%0d cyc=%0d expected error=%0d pc=%0d cyc=%0d",
                     id, d, e, pc, cyc, x.err, x.pc, x.cyc);
        end
    endtask

    always @(negedge sys_clk) begin
        if (ifa.done || ifa.error) check(0, ifa.done, ifa.error, int'(ifa.match_pc));
        if (ifb.done || ifb.error) check(1, ifb.done, ifb.error, int'(ifb.match_pc));
        if (ifc.done || ifc.error) check(2, ifc.done, ifc.error, int'(ifc.match_pc));
    end

    task automatic drive(input int id, input logic st, input logic d, input int pc);
        case (id)
            0:       begin ifa.start = st; ifa.dir = d; ifa.start_pc = 9'(pc); end
            1:       begin ifb.start = st; ifb.dir = d; ifb.start_pc = 9'(pc); end
            default: begin ifc.start = st; ifc.dir = d; ifc.start_pc = 9'(pc); end
        endcase
    endtask

    function automatic int get_busy(input int id);
        case (id)
            0:       return int'(ifa.busy);
            1:       return int'(ifb.busy);
            default: return int'(ifc.busy);
        endcase
    endfunction

    task automatic wait_idle(input int id);
        for (int i = 0; i < 64; i++) begin
            if (qsize(id) == 0) break;
            @(negedge sys_clk);
        end
        n_cmp++;
        if (qsize(id) != 0) begin
            n_bad++;
            $display("FAIL timeout inst%0d: got %0d pending results expected 0", id, qsize(id));
            case (id)
                0:       q0.delete();
                1:       q1.delete();
                default: q2.delete();
            endcase
        end
    endtask

    // k = cycles from the start edge to the result edge; the result is seen the cycle after.
    task automatic scan(input int id, input bit d, input int spc, input bit err, input int epc, input int k);
        @(negedge sys_clk);
        push(id, err, epc, cyc + 1 + k);
        drive(id, 1'b1, d, spc);
        @(negedge sys_clk);
        drive(id, 1'b0, d, spc);
        cmp($sformatf("busy_after_start inst%0d pc%0d", id, spc), get_busy(id), (k > 0) ? 1 : 0);
        wait_idle(id);
    endtask

    initial begin
        string s0, s1, s2;
        s0 = "+[-[>]<].";
        s1 = "[[]";
        s2 = "[[[[[]]]]]";
        for (int i = 0; i < 512; i++) begin
            rom0[i] = 8'h00; rom1[i] = 8'h00; rom2[i] = 8'h00;
        end
        for (int i = 0; i < s0.len(); i++) rom0[i] = s0[i];
        for (int i = 0; i < s1.len(); i++) rom1[i] = s1[i];
        for (int i = 0; i < s2.len(); i++) rom2[i] = s2[i];
        drive(0, 1'b0, 1'b0, 0);
        drive(1, 1'b0, 1'b0, 0);
        drive(2, 1'b0, 1'b0, 0);

        #1;
        cmp("rst_busy_a",  int'(ifa.busy), 0);
        cmp("rst_done_a",  int'(ifa.done), 0);
        cmp("rst_error_a", int'(ifa.error), 0);
        cmp("rst_addr_a",  int'(ifa.rom_addr), 0);
        cmp("rst_match_a", int'(ifa.match_pc), 0);
        cmp("rst_busy_c",  int'(ifc.busy), 0);
        repeat (3) @(negedge sys_clk);
        rst = 1'b0;

        // Nested loop program, forward and backward.
        scan(0, 1'b0, 1, 1'b0, 7, 6);
        scan(0, 1'b0, 3, 1'b0, 5, 2);
        scan(0, 1'b1, 7, 1'b0, 1, 6);
        scan(0, 1'b1, 5, 1'b0, 3, 2);
        // Start on the program edges: immediate error, match_pc held.
        scan(0, 1'b0, 8, 1'b1, 3, 0);
        scan(0, 1'b1, 0, 1'b1, 3, 0);

        // Reset asserted mid-scan: outputs clear at once, no result pulse.
        @(negedge sys_clk);
        drive(0, 1'b1, 1'b0, 1);
        @(negedge sys_clk);
        drive(0, 1'b0, 1'b0, 1);
        repeat (2) @(posedge sys_clk);
        #1 rst = 1'b1;
        #1;
        cmp("midrst_busy",  int'(ifa.busy), 0);
        cmp("midrst_done",  int'(ifa.done), 0);
        cmp("midrst_error", int'(ifa.error), 0);
        cmp("midrst_addr",  int'(ifa.rom_addr), 0);
        cmp("midrst_match", int'(ifa.match_pc), 0);
        @(negedge sys_clk);
        rst = 1'b0;
        scan(0, 1'b0, 1, 1'b0, 7, 6);

        // start held high through a whole scan and its DONE: exactly one IDLE gap, then a rescan.
        @(negedge sys_clk);
        push(0, 1'b0, 7, cyc + 1 + 6);
        push(0, 1'b0, 7, cyc + 1 + 14);
        drive(0, 1'b1, 1'b0, 1);
        repeat (10) @(negedge sys_clk);
        drive(0, 1'b0, 1'b0, 1);
        wait_idle(0);

        // Short program: runs off the end while still nested.
        scan(1, 1'b1, 2, 1'b0, 1, 1);
        scan(1, 1'b0, 0, 1'b1, 1, 2);
        scan(1, 1'b1, 0, 1'b1, 1, 0);

        // Two-bit depth counter: the fourth open bracket overflows.
        scan(2, 1'b0, 4, 1'b0, 5, 1);
        scan(2, 1'b0, 0, 1'b1, 5, 4);
        scan(2, 1'b1, 9, 1'b1, 5, 4);

        repeat (4) @(negedge sys_clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test expected finish before time limit");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/bf_loop_scanner.md
Name: bf_loop_scanner

Overview:
- Resolves bracket jumps for the bf core by scanning program memory for the matching '[' or ']'.
- Used in two cases: a forward skip when '[' sees cell==0, and a backward jump when ']' sees cell!=0.
- Walks the program one instruction per cycle, tracking nesting with an up/down depth counter.
- Returns the address of the matching bracket, or flags an error if no match exists.

Parameters:
- ADDR_W, 9, program address width; program memory is 2**ADDR_W bytes max.
- DEPTH_W, 9, nesting-depth counter width; max depth 2**DEPTH_W-1.
- PROG_LEN, 512, number of valid program bytes; addresses 0..PROG_LEN-1.

Ports:
- sys_clk  in  1  system clock, rising edge.
- rst  in  1  reset.
- start  in  1  request scan; sampled only in IDLE.
- dir  in  1  0 = forward (from '[', find ']'), 1 = backward (from ']', find '[').
- start_pc  in  ADDR_W  address of the bracket that triggered the scan.
- rom_addr  out  ADDR_W  program memory read address (registered).
- rom_data  in  8  ASCII byte at rom_addr; combinational read, valid in the same cycle.
- busy  out  1  high while in SCAN.
- done  out  1  one-cycle pulse: match found.
- match_pc  out  ADDR_W  matching bracket address; valid from done onward, held until the next done.
- error  out  1  one-cycle pulse: scan failed.

Behaviour:
- Reset: rst is asynchronous and active-high; sys_clk is the single clock. While rst=1:
  - state=IDLE
  - rom_addr=0, match_pc=0, depth=0
  - busy=0, done=0, error=0
- States: IDLE, SCAN, DONE, ERR.
- IDLE, start=1 at edge E0:
  - Latch dir; depth<=0.
  - Forward: if start_pc>=PROG_LEN-1, go to ERR; else rom_addr<=start_pc+1 and go to SCAN.
  - Backward: if start_pc==0, go to ERR; else rom_addr<=start_pc-1 and go to SCAN.
  - The bracket at start_pc is never itself examined.
- SCAN, each cycle, examines rom_data at rom_addr. Forward ('[' opens, ']' closes):
  - Close and depth==0: match_pc<=rom_addr, go to DONE.
  - Close and depth>0: depth--, advance.
  - Open and depth==2**DEPTH_W-1: go to ERR (overflow).
  - Open otherwise: depth++, advance.
  - Any other byte: advance, depth unchanged.
- SCAN, backward: same rules with roles swapped (']' opens, '[' closes).
- Advance: rom_addr+1 forward, rom_addr-1 backward.
  - Forward: if the unmatched byte sits at PROG_LEN-1, go to ERR instead of advancing.
  - Backward: if it sits at address 0, go to ERR instead of advancing.
  - Address never wraps.
- DONE: done=1 for exactly one cycle, then IDLE.
- ERR: error=1 for exactly one cycle, then IDLE. match_pc is unchanged on error.
- Latency: with k = |match_pc - start_pc|, done is high in the cycle after edge E0+k.
  - Immediate-boundary error: error is high in the cycle after E0.
- busy=1 exactly while in SCAN. start is ignored in SCAN, DONE and ERR, with no queuing.
- start held high continuously starts a new scan on the first IDLE cycle after DONE/ERR.
- done and error are never high together.
- rom_addr holds its last value in IDLE, DONE and ERR.
- rst mid-scan: immediate return to IDLE; no done or error pulse is produced.
- Depth arithmetic is unsigned DEPTH_W bits; increment is guarded against overflow; decrement only occurs when depth>0.

Test Plan:
- Program "+[-[>]<]." at 0..8 (PROG_LEN=9), dir=0, start_pc=1 -> busy for 6 cycles, done in the cycle after E0+6, match_pc=7, depth passes through 1 and back to 0.
- Same program, dir=0, start_pc=3 -> done after E0+2, match_pc=5. Then dir=1, start_pc=7 -> match_pc=1; dir=1, start_pc=5 -> match_pc=3.
- Program "[[]" (PROG_LEN=3), dir=0, start_pc=0 -> error pulse in the cycle after E0+2, no done, match_pc keeps its previous value. Separately: dir=1, start_pc=0 -> error in the cycle after E0.
- DEPTH_W=2, program "[[[[[]]]]]", dir=0, start_pc=0 -> depth reaches 3, the '[' at address 4 triggers error after E0+4.
- Assert rst during SCAN of the first scenario at cycle 3 -> busy=0, done=0, error=0, rom_addr=0 immediately. A subsequent clean start from start_pc=1 completes with match_pc=7.
- Pulse start again during SCAN and hold start high through DONE -> mid-scan start is ignored; a second scan begins on the IDLE cycle after DONE; done pulses are separated by ≥1 IDLE cycle.
